// File: rtl/agu_rs.sv
// agu_rs: address-generation reservation station feeding the load/store queue.
// Holds load/store uops until both sources are woken by the CDB, then reads the
// PRF, forms address / byte mask / lane-shifted store data and sends a one-cycle
// registered update keyed by rob_id.
// Optional build macro AGU_AGE_SELECT_EN: oldest-ready select via per-entry
// saturating age counters; when undefined, lowest-index select with no age state.
module agu_rs #(
    parameter int RS_DEPTH  = 4,
    parameter int ROB_ID_W  = 5,
    parameter int PRF_IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 backend_flush,
    input  logic                 ds_valid,
    output logic                 ds_ready,
    input  logic [ROB_ID_W-1:0]  ds_rob_id,
    input  logic [3:0]           ds_fu_opcode,
    input  logic [PRF_IDX_W-1:0] ds_rs1_phy,
    input  logic [PRF_IDX_W-1:0] ds_rs2_phy,
    input  logic                 ds_rs1_rdy,
    input  logic                 ds_rs2_rdy,
    input  logic [31:0]          ds_imm,
    input  logic                 cdb_valid,
    input  logic [PRF_IDX_W-1:0] cdb_rd_phy,
    output logic [PRF_IDX_W-1:0] prf_rs1_idx,
    output logic [PRF_IDX_W-1:0] prf_rs2_idx,
    input  logic [31:0]          prf_rs1_value,
    input  logic [31:0]          prf_rs2_value,
    output logic                 agu_valid,
    output logic [ROB_ID_W-1:0]  agu_rob_id,
    output logic [31:0]          agu_addr,
    output logic [3:0]           agu_mask,
    output logic [31:0]          agu_wdata,
    output logic [31:0]          agu_rs1_value_dbg,
    output logic [31:0]          agu_rs2_value_dbg
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    typedef struct packed {
        logic                 valid;
        logic [ROB_ID_W-1:0]  rob_id;
        logic [3:0]           op;
        logic [PRF_IDX_W-1:0] rs1_phy;
        logic [PRF_IDX_W-1:0] rs2_phy;
        logic                 rs1_rdy;
        logic                 rs2_rdy;
        logic [31:0]          imm;
`ifdef AGU_AGE_SELECT_EN
        logic [IDX_W-1:0]     age;
`endif
    } entry_t;

    entry_t ent_q [RS_DEPTH];
    entry_t ent_d [RS_DEPTH];

    logic             free_any;
    logic [IDX_W-1:0] alloc_idx;
    logic             do_alloc;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [31:0]      ex_addr;
    logic [3:0]       ex_mask;
    logic [31:0]      ex_wdata;

    logic                agu_valid_q, agu_valid_d;
    logic [ROB_ID_W-1:0] agu_rob_id_q, agu_rob_id_d;
    logic [31:0]         agu_addr_q, agu_addr_d;
    logic [3:0]          agu_mask_q, agu_mask_d;
    logic [31:0]         agu_wdata_q, agu_wdata_d;
    logic [31:0]         rs1_dbg_q, rs1_dbg_d;
    logic [31:0]         rs2_dbg_q, rs2_dbg_d;

    // Lowest-index free entry, judged on start-of-cycle occupancy only
    always_comb begin
        free_any  = 1'b0;
        alloc_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                free_any  = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign ds_ready = free_any;
    assign do_alloc = ds_valid && free_any && !backend_flush;

    // Issue select; entries allocated this cycle are not yet in ent_q so are never picked
`ifdef AGU_AGE_SELECT_EN
    logic [IDX_W-1:0] best_age;
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy &&
                (!sel_found || ent_q[i].age > best_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = ent_q[i].age;
            end
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    assign prf_rs1_idx = ent_q[sel_idx].rs1_phy;
    assign prf_rs2_idx = ent_q[sel_idx].rs2_phy;

    // Address, byte mask and lane-shifted store data for the selected entry
    always_comb begin
        ex_addr  = prf_rs1_value + ent_q[sel_idx].imm;
        ex_mask  = 4'b1111;
        ex_wdata = prf_rs2_value;
        case (ent_q[sel_idx].op[1:0])
            2'b00: begin
                ex_mask  = 4'b0001 << ex_addr[1:0];
                ex_wdata = prf_rs2_value << {ex_addr[1:0], 3'b000};
            end
            2'b01: begin
                ex_mask  = 4'b0011 << {ex_addr[1], 1'b0};
                ex_wdata = prf_rs2_value << {ex_addr[1], 4'b0000};
            end
            default: begin
                ex_mask  = 4'b1111;
                ex_wdata = prf_rs2_value;
            end
        endcase
        if (!ent_q[sel_idx].op[3]) begin
            ex_wdata = '0;
        end
    end

    // Entry next state: wakeup, free on issue, allocate, flush has final say
    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ent_q[i].valid && cdb_valid) begin
                if (ent_q[i].rs1_phy == cdb_rd_phy) ent_d[i].rs1_rdy = 1'b1;
                if (ent_q[i].rs2_phy == cdb_rd_phy) ent_d[i].rs2_rdy = 1'b1;
            end
        end
        if (sel_found) begin
            ent_d[sel_idx].valid = 1'b0;
        end
        if (do_alloc) begin
`ifdef AGU_AGE_SELECT_EN
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (ent_q[i].valid && ent_q[i].age != '1) begin
                    ent_d[i].age = ent_q[i].age + 1'b1;
                end
            end
            ent_d[alloc_idx].age = '0;
`endif
            ent_d[alloc_idx].valid   = 1'b1;
            ent_d[alloc_idx].rob_id  = ds_rob_id;
            ent_d[alloc_idx].op      = ds_fu_opcode;
            ent_d[alloc_idx].rs1_phy = ds_rs1_phy;
            ent_d[alloc_idx].rs2_phy = ds_rs2_phy;
            ent_d[alloc_idx].imm     = ds_imm;
            ent_d[alloc_idx].rs1_rdy = ds_rs1_rdy || (ds_rs1_phy == '0) ||
                                       (cdb_valid && cdb_rd_phy == ds_rs1_phy);
            // Loads never read rs2, so it is born ready
            ent_d[alloc_idx].rs2_rdy = !ds_fu_opcode[3] || ds_rs2_rdy || (ds_rs2_phy == '0) ||
                                       (cdb_valid && cdb_rd_phy == ds_rs2_phy);
        end
        if (backend_flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_d[i] = '0;
            end
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            ent_q <= ent_d;
        end
    end

    // Output register next state: capture on issue, cleared by flush
    always_comb begin
        agu_valid_d  = sel_found;
        agu_rob_id_d = agu_rob_id_q;
        agu_addr_d   = agu_addr_q;
        agu_mask_d   = agu_mask_q;
        agu_wdata_d  = agu_wdata_q;
        rs1_dbg_d    = rs1_dbg_q;
        rs2_dbg_d    = rs2_dbg_q;
        if (sel_found) begin
            agu_rob_id_d = ent_q[sel_idx].rob_id;
            agu_addr_d   = ex_addr;
            agu_mask_d   = ex_mask;
            agu_wdata_d  = ex_wdata;
            rs1_dbg_d    = prf_rs1_value;
            rs2_dbg_d    = prf_rs2_value;
        end
        if (backend_flush) begin
            agu_valid_d  = 1'b0;
            agu_rob_id_d = '0;
            agu_addr_d   = '0;
            agu_mask_d   = '0;
            agu_wdata_d  = '0;
            rs1_dbg_d    = '0;
            rs2_dbg_d    = '0;
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            agu_valid_q  <= 1'b0;
            agu_rob_id_q <= '0;
            agu_addr_q   <= '0;
            agu_mask_q   <= '0;
            agu_wdata_q  <= '0;
            rs1_dbg_q    <= '0;
            rs2_dbg_q    <= '0;
        end else begin
            agu_valid_q  <= agu_valid_d;
            agu_rob_id_q <= agu_rob_id_d;
            agu_addr_q   <= agu_addr_d;
            agu_mask_q   <= agu_mask_d;
            agu_wdata_q  <= agu_wdata_d;
            rs1_dbg_q    <= rs1_dbg_d;
            rs2_dbg_q    <= rs2_dbg_d;
        end
    end

    assign agu_valid         = agu_valid_q;
    assign agu_rob_id        = agu_rob_id_q;
    assign agu_addr          = agu_addr_q;
    assign agu_mask          = agu_mask_q;
    assign agu_wdata         = agu_wdata_q;
    assign agu_rs1_value_dbg = rs1_dbg_q;
    assign agu_rs2_value_dbg = rs2_dbg_q;

endmodule

// File: tb/tb_agu_rs.sv
// Directed bench for agu_rs: table of single-uop execute vectors plus
// hand-written wakeup, bypass, full, flush, select-order and async-reset sequences.
module tb_agu_rs;

    logic        clk = 1'b0;
    logic        rst;
    logic        backend_flush;
    logic        ds_valid;
    logic        ds_ready;
    logic [4:0]  ds_rob_id;
    logic [3:0]  ds_fu_opcode;
    logic [5:0]  ds_rs1_phy, ds_rs2_phy;
    logic        ds_rs1_rdy, ds_rs2_rdy;
    logic [31:0] ds_imm;
    logic        cdb_valid;
    logic [5:0]  cdb_rd_phy;
    logic [5:0]  prf_rs1_idx, prf_rs2_idx;
    logic [31:0] prf_rs1_value, prf_rs2_value;
    logic        agu_valid;
    logic [4:0]  agu_rob_id;
    logic [31:0] agu_addr;
    logic [3:0]  agu_mask;
    logic [31:0] agu_wdata;
    logic [31:0] agu_rs1_value_dbg, agu_rs2_value_dbg;

    logic [31:0] prf_mem [64];
    assign prf_rs1_value = prf_mem[prf_rs1_idx];
    assign prf_rs2_value = prf_mem[prf_rs2_idx];

    always #5 clk = ~clk;

    agu_rs #(.RS_DEPTH(4), .ROB_ID_W(5), .PRF_IDX_W(6)) dut (
        .clk(clk), .rst(rst), .backend_flush(backend_flush),
        .ds_valid(ds_valid), .ds_ready(ds_ready), .ds_rob_id(ds_rob_id),
        .ds_fu_opcode(ds_fu_opcode), .ds_rs1_phy(ds_rs1_phy), .ds_rs2_phy(ds_rs2_phy),
        .ds_rs1_rdy(ds_rs1_rdy), .ds_rs2_rdy(ds_rs2_rdy), .ds_imm(ds_imm),
        .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy),
        .prf_rs1_idx(prf_rs1_idx), .prf_rs2_idx(prf_rs2_idx),
        .prf_rs1_value(prf_rs1_value), .prf_rs2_value(prf_rs2_value),
        .agu_valid(agu_valid), .agu_rob_id(agu_rob_id), .agu_addr(agu_addr),
        .agu_mask(agu_mask), .agu_wdata(agu_wdata),
        .agu_rs1_value_dbg(agu_rs1_value_dbg), .agu_rs2_value_dbg(agu_rs2_value_dbg)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs [8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [4:0] rob, input logic [3:0] op,
                            input logic [5:0] p1, input logic r1,
                            input logic [5:0] p2, input logic r2, input logic [31:0] imm);
        ds_valid     = 1'b1;
        ds_rob_id    = rob;
        ds_fu_opcode = op;
        ds_rs1_phy   = p1;
        ds_rs1_rdy   = r1;
        ds_rs2_phy   = p2;
        ds_rs2_rdy   = r2;
        ds_imm       = imm;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) prf_mem[i] = 32'h0;
        //              op       rs1           rs2           imm           addr          mask     wdata
        vecs[0] = '{4'b0010, 32'h0000_1000, 32'h5555_5555, 32'h0000_0008, 32'h0000_1008, 4'b1111, 32'h0000_0000};
        vecs[1] = '{4'b1000, 32'h0000_2003, 32'h0000_00AB, 32'h0000_0000, 32'h0000_2003, 4'b1000, 32'hAB00_0000};
        vecs[2] = '{4'b1001, 32'h0000_2000, 32'h0000_1234, 32'h0000_0002, 32'h0000_2002, 4'b1100, 32'h1234_0000};
        vecs[3] = '{4'b1010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0000_00FC, 4'b1111, 32'hDEAD_BEEF};
        vecs[4] = '{4'b0100, 32'h0000_3001, 32'h1111_1111, 32'h0000_0000, 32'h0000_3001, 4'b0010, 32'h0000_0000};
        vecs[5] = '{4'b0001, 32'hFFFF_FFFF, 32'h2222_2222, 32'h0000_0001, 32'h0000_0000, 4'b0011, 32'h0000_0000};
        vecs[6] = '{4'b1000, 32'h0000_0010, 32'h0000_01FF, 32'h0000_0001, 32'h0000_0011, 4'b0010, 32'h0001_FF00};
        vecs[7] = '{4'b0101, 32'h0000_4000, 32'h3333_3333, 32'h0000_0003, 32'h0000_4003, 4'b1100, 32'h0000_0000};

        rst = 1'b0; backend_flush = 1'b0; ds_valid = 1'b0; ds_rob_id = '0;
        ds_fu_opcode = '0; ds_rs1_phy = '0; ds_rs2_phy = '0; ds_rs1_rdy = 1'b0;
        ds_rs2_rdy = 1'b0; ds_imm = '0; cdb_valid = 1'b0; cdb_rd_phy = '0;

        step(); step();
        chk("reset agu_valid", {31'b0, agu_valid}, 32'h0);
        chk("reset agu_addr", agu_addr, 32'h0);
        chk("reset agu_wdata", agu_wdata, 32'h0);
        rst = 1'b1;
        step();
        chk("reset ds_ready", {31'b0, ds_ready}, 32'h1);

        // Execute vectors: dispatch with ready sources, result two cycles later
        for (int v = 0; v < 8; v++) begin
            prf_mem[10] = vecs[v].rs1;
            prf_mem[11] = vecs[v].rs2;
            set_disp(5'(v + 1), vecs[v].op, 6'd10, 1'b1, 6'd11, 1'b1, vecs[v].imm);
            step();
            ds_valid = 1'b0;
            chk($sformatf("v%0d valid_issue_cycle", v), {31'b0, agu_valid}, 32'h0);
            step();
            chk($sformatf("v%0d valid", v), {31'b0, agu_valid}, 32'h1);
            chk($sformatf("v%0d rob", v), {27'b0, agu_rob_id}, 32'(v + 1));
            chk($sformatf("v%0d addr", v), agu_addr, vecs[v].addr);
            chk($sformatf("v%0d mask", v), {28'b0, agu_mask}, {28'b0, vecs[v].mask});
            chk($sformatf("v%0d wdata", v), agu_wdata, vecs[v].wdata);
            chk($sformatf("v%0d dbg1", v), agu_rs1_value_dbg, vecs[v].rs1);
            chk($sformatf("v%0d dbg2", v), agu_rs2_value_dbg, vecs[v].rs2);
            step();
            chk($sformatf("v%0d pulse", v), {31'b0, agu_valid}, 32'h0);
        end

        // Wakeup: rs1 on phy 7 not ready; CDB at cycle 3 -> issue 4 -> valid 5
        prf_mem[7] = 32'h0000_0500;
        set_disp(5'd20, 4'b0010, 6'd7, 1'b0, 6'd0, 1'b0, 32'h4);
        step();
        ds_valid = 1'b0;
        step();
        chk("wake c2 idle", {31'b0, agu_valid}, 32'h0);
        step();
        cdb_valid = 1'b1; cdb_rd_phy = 6'd7;
        chk("wake c3 idle", {31'b0, agu_valid}, 32'h0);
        step();
        cdb_valid = 1'b0;
        chk("wake c4 prf_idx", {26'b0, prf_rs1_idx}, 32'd7);
        chk("wake c4 idle", {31'b0, agu_valid}, 32'h0);
        step();
        chk("wake c5 valid", {31'b0, agu_valid}, 32'h1);
        chk("wake c5 addr", agu_addr, 32'h0000_0504);
        step();

        // Allocation bypass: CDB hits phy 9 in the dispatch cycle
        prf_mem[9] = 32'h0000_0700;
        set_disp(5'd21, 4'b0010, 6'd9, 1'b0, 6'd0, 1'b0, 32'h0);
        cdb_valid = 1'b1; cdb_rd_phy = 6'd9;
        step();
        ds_valid = 1'b0; cdb_valid = 1'b0;
        step();
        chk("bypass valid", {31'b0, agu_valid}, 32'h1);
        chk("bypass addr", agu_addr, 32'h0000_0700);
        step();

        // Full: four blocked loads on phys 20..23
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fill ready %0d", k), {31'b0, ds_ready}, 32'h1);
            set_disp(5'(10 + k), 4'b0010, 6'(20 + k), 1'b0, 6'd0, 1'b0, 32'(k * 16));
            step();
        end
        ds_valid = 1'b0;
        chk("full ds_ready", {31'b0, ds_ready}, 32'h0);
        cdb_valid = 1'b1; cdb_rd_phy = 6'd22;
        step();
        cdb_valid = 1'b0;
        chk("full issue ds_ready", {31'b0, ds_ready}, 32'h0);
        chk("full issue idx", {26'b0, prf_rs1_idx}, 32'd22);
        cdb_valid = 1'b1; cdb_rd_phy = 6'd20;
        step();
        cdb_valid = 1'b0;
        chk("full after ds_ready", {31'b0, ds_ready}, 32'h1);
        chk("full after valid", {31'b0, agu_valid}, 32'h1);
        chk("full after rob", {27'b0, agu_rob_id}, 32'd12);

        // Flush with 3 entries valid, one issuing, and a ready dispatch that must drop
        chk("flush issue idx", {26'b0, prf_rs1_idx}, 32'd20);
        backend_flush = 1'b1;
        set_disp(5'd31, 4'b0010, 6'd0, 1'b1, 6'd0, 1'b1, 32'h40);
        step();
        backend_flush = 1'b0; ds_valid = 1'b0;
        chk("flush agu_valid", {31'b0, agu_valid}, 32'h0);
        chk("flush ds_ready", {31'b0, ds_ready}, 32'h1);
        cdb_valid = 1'b1; cdb_rd_phy = 6'd21;
        step();
        cdb_rd_phy = 6'd23;
        step();
        cdb_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("post flush quiet %0d", k), {31'b0, agu_valid}, 32'h0);
            step();
        end

        // Select order: entry 1 older, entry 0 newer, both woken by phy 5 together
        set_disp(5'd1, 4'b0010, 6'd0, 1'b1, 6'd0, 1'b1, 32'h0);
        step();
        set_disp(5'd2, 4'b0010, 6'd5, 1'b0, 6'd0, 1'b0, 32'h0);
        step();
        set_disp(5'd3, 4'b0010, 6'd5, 1'b0, 6'd0, 1'b0, 32'h0);
        step();
        ds_valid = 1'b0;
        cdb_valid = 1'b1; cdb_rd_phy = 6'd5;
        step();
        cdb_valid = 1'b0;
        step();
        chk("order first valid", {31'b0, agu_valid}, 32'h1);
`ifdef AGU_AGE_SELECT_EN
        chk("order first rob", {27'b0, agu_rob_id}, 32'd2);
`else
        chk("order first rob", {27'b0, agu_rob_id}, 32'd3);
`endif
        step();
        chk("order second valid", {31'b0, agu_valid}, 32'h1);
`ifdef AGU_AGE_SELECT_EN
        chk("order second rob", {27'b0, agu_rob_id}, 32'd3);
`else
        chk("order second rob", {27'b0, agu_rob_id}, 32'd2);
`endif
        step();

        // Async reset while a result is being presented
        prf_mem[12] = 32'h0000_8000;
        prf_mem[13] = 32'hCAFE_F00D;
        set_disp(5'd7, 4'b1010, 6'd12, 1'b1, 6'd13, 1'b1, 32'h4);
        step();
        ds_valid = 1'b0;
        step();
        chk("pre-reset valid", {31'b0, agu_valid}, 32'h1);
        chk("pre-reset addr", agu_addr, 32'h0000_8004);
        #2 rst = 1'b0;
        #1;
        chk("async rst valid", {31'b0, agu_valid}, 32'h0);
        chk("async rst addr", agu_addr, 32'h0);
        chk("async rst mask", {28'b0, agu_mask}, 32'h0);
        chk("async rst wdata", agu_wdata, 32'h0);
        chk("async rst dbg1", agu_rs1_value_dbg, 32'h0);
        chk("async rst dbg2", agu_rs2_value_dbg, 32'h0);
        chk("async rst rob", {27'b0, agu_rob_id}, 32'h0);
        step();
        rst = 1'b1;
        step();
        chk("post-reset ds_ready", {31'b0, ds_ready}, 32'h1);
        chk("post-reset quiet", {31'b0, agu_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
